// File: rtl/matrix_stream_host.sv
// matrix_stream_host: host-side sequencer for a streaming matrix accelerator.
// Operands (A then B, row-major) are loaded into op_buf while idle and
// streamed out over m_axis. Results come back over s_axis into res_buf,
// which is readable at any time through rd_addr/rd_data.
//
// Handshake rule for both streams: a beat transfers on a rising clk edge
// where tvalid and tready are both 1. The master never drops tvalid or
// changes tdata while a beat is pending. The slave may accept results while
// operands are still being sent.
module matrix_stream_host #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 32,
    parameter int N       = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        tlast_err,
    output logic                        timeout,
    output logic                        accel_start,
    input  logic                        ld_we,
    input  logic [$clog2(2*N*N)-1:0]    ld_addr,
    input  logic [DATA_W-1:0]           ld_data,
    input  logic [$clog2(N*N)-1:0]      rd_addr,
    output logic [ACC_W-1:0]            rd_data,
    output logic                        m_axis_tvalid,
    output logic [DATA_W-1:0]           m_axis_tdata,
    input  logic                        m_axis_tready,
    input  logic                        s_axis_tvalid,
    input  logic [ACC_W-1:0]            s_axis_tdata,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready
);

    localparam int OPS    = 2 * N * N;
    localparam int RES    = N * N;
    localparam int LD_AW  = $clog2(OPS);
    localparam int RD_AW  = $clog2(RES);
    localparam int IDX_W  = $clog2(OPS + 1);
    localparam int RIDX_W = $clog2(RES + 1);
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_KICK = 3'd1,
        S_SEND = 3'd2,
        S_RECV = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    // Current FSM state; kept as a named enum so checkers can bind to it.
    state_t state;
    state_t state_nx;

    logic [DATA_W-1:0] op_buf  [OPS];
    logic [ACC_W-1:0]  res_buf [RES];

    logic [IDX_W-1:0]  send_idx;
    logic [RIDX_W-1:0] recv_idx;
    logic [WD_W-1:0]   wdog;

    logic m_fire;
    logic s_fire;
    logic last_op;
    logic last_res;
    logic res_full;
    logic wdog_hit;
    logic tlast_bad;

    assign m_fire    = m_axis_tvalid && m_axis_tready;
    assign s_fire    = s_axis_tvalid && s_axis_tready;
    assign last_op   = (send_idx == IDX_W'(OPS - 1));
    assign last_res  = (recv_idx == RIDX_W'(RES - 1));
    assign res_full  = (recv_idx == RIDX_W'(RES));
    // The watchdog fires on the cycle that would bring the idle count to TIMEOUT.
    assign wdog_hit  = (state == S_RECV) && !s_fire && (wdog == WD_W'(TIMEOUT - 1));
    // tlast must appear on exactly the final result beat.
    assign tlast_bad = s_fire && (s_axis_tlast != last_res);

    assign m_axis_tdata = (int'(send_idx) < OPS) ? op_buf[send_idx[LD_AW-1:0]] : '0;
    assign rd_data      = (int'(rd_addr) < RES) ? res_buf[rd_addr] : '0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; a result set completed during SEND skips RECV.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_KICK;
            S_KICK: state_nx = S_SEND;
            S_SEND: begin
                if (m_fire && last_op)
                    state_nx = (res_full || (s_fire && last_res)) ? S_FIN : S_RECV;
            end
            S_RECV: begin
                if (s_fire && last_res) state_nx = S_FIN;
                else if (wdog_hit)      state_nx = S_FIN;
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Per-state outputs; result intake stops once the buffer is full.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        accel_start   = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        case (state)
            S_KICK: begin
                busy        = 1'b1;
                accel_start = 1'b1;
            end
            S_SEND: begin
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
                s_axis_tready = !res_full;
            end
            S_RECV: begin
                busy          = 1'b1;
                s_axis_tready = !res_full;
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    // Operand index: restarts at 0 on every kick, advances per transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           send_idx <= '0;
        else if (state == S_KICK)          send_idx <= '0;
        else if (state == S_SEND && m_fire) send_idx <= send_idx + IDX_W'(1);
    end

    // Result index: restarts at 0 on every kick, advances per accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  recv_idx <= '0;
        else if (state == S_KICK) recv_idx <= '0;
        else if (s_fire)          recv_idx <= recv_idx + RIDX_W'(1);
    end

    // Watchdog: counts idle cycles in RECV, cleared by any accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            wdog <= '0;
        else if (state != S_RECV || s_fire) wdog <= '0;
        else if (wdog != WD_W'(TIMEOUT))    wdog <= wdog + WD_W'(1);
    end

    // Sticky error flags, cleared only when a new transaction kicks off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlast_err <= 1'b0;
            timeout   <= 1'b0;
        end else if (state == S_KICK) begin
            tlast_err <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (tlast_bad) tlast_err <= 1'b1;
            if (wdog_hit)  timeout   <= 1'b1;
        end
    end

    // Operand buffer: host writes are accepted only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OPS; i++) op_buf[i] <= '0;
        end else if (state == S_IDLE && ld_we && int'(ld_addr) < OPS) begin
            op_buf[ld_addr] <= ld_data;
        end
    end

    // Result buffer: each accepted beat lands at the current result index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RES; i++) res_buf[i] <= '0;
        end else if (s_fire) begin
            res_buf[recv_idx[RD_AW-1:0]] <= s_axis_tdata;
        end
    end

endmodule

// File: tb/tb_matrix_stream_host.sv
// Bench for matrix_stream_host: random operands and results, a queue of
// expected operand beats popped by a monitor, and a per-index result model.
module tb_matrix_stream_host;

  localparam int DATA_W  = 16;
  localparam int ACC_W   = 32;
  localparam int N       = 4;
  localparam int TIMEOUT = 20;
  localparam int OPS     = 2 * N * N;
  localparam int RES     = N * N;
  localparam int LD_AW   = $clog2(OPS);
  localparam int RD_AW   = $clog2(RES);

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              tlast_err;
  logic              timeout;
  logic              accel_start;
  logic              ld_we;
  logic [LD_AW-1:0]  ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [RD_AW-1:0]  rd_addr;
  logic [ACC_W-1:0]  rd_data;
  logic              m_axis_tvalid;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tready;
  logic              s_axis_tvalid;
  logic [ACC_W-1:0]  s_axis_tdata;
  logic              s_axis_tlast;
  logic              s_axis_tready;

  matrix_stream_host #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .N(N), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .tlast_err(tlast_err), .timeout(timeout), .accel_start(accel_start),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tready(m_axis_tready),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation still running at %0t, limit 500000", $time);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] op_model  [OPS];
  logic [ACC_W-1:0]  res_model [RES];

  int vectors    = 0;
  int miscompares = 0;
  int acc_cnt    = 0;
  int done_cnt   = 0;
  int beat_cnt   = 0;
  int acc_cyc    = 0;
  int to_cyc     = -1;
  bit rand_ready = 1'b0;

  logic              mon_prev_stall = 1'b0;
  logic [DATA_W-1:0] mon_prev_data  = '0;
  logic              mon_prev_to    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic load_ops(input bit pattern);
    logic [DATA_W-1:0] val;
    for (int i = 0; i < OPS; i++) begin
      @(posedge clk);
      #1;
      val = pattern ? DATA_W'(i + 1) : DATA_W'($urandom);
      ld_we = 1'b1;
      ld_addr = LD_AW'(i);
      ld_data = val;
      op_model[i] = val;
    end
    @(posedge clk);
    #1 ld_we = 1'b0;
  endtask

  // Writes issued while the block is busy must leave op_buf untouched,
  // so op_model is deliberately not updated here.
  task automatic busy_write_burst();
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      ld_we = 1'b1;
      ld_addr = LD_AW'($urandom_range(0, OPS - 1));
      ld_data = DATA_W'($urandom);
    end
    @(posedge clk);
    #1 ld_we = 1'b0;
  endtask

  task automatic send_results(input int n, input int tlast_at, input int base, input bit wait_recv);
    bit ok;
    logic [ACC_W-1:0] val;
    if (wait_recv) begin
      ok = 1'b0;
      for (int w = 0; w < 200; w++) begin
        @(negedge clk);
        if (busy && !m_axis_tvalid && !accel_start) begin
          ok = 1'b1;
          break;
        end
      end
      check("recv_reached", ok, 1);
      @(posedge clk);
    end else begin
      repeat (3) @(posedge clk);
    end
    for (int k = 0; k < n; k++) begin
      #1;
      val = (base >= 0) ? ACC_W'(base + k) : ACC_W'($urandom);
      s_axis_tvalid = 1'b1;
      s_axis_tdata = val;
      s_axis_tlast = (k == tlast_at);
      ok = 1'b0;
      for (int w = 0; w < 100; w++) begin
        @(negedge clk);
        if (s_axis_tready) begin
          ok = 1'b1;
          acc_cyc = cyc;
        end
        @(posedge clk);
        if (ok) break;
      end
      check("s_accept", ok, 1);
      if (!ok) begin
        s_axis_tvalid = 1'b0;
        return;
      end
      res_model[k] = val;
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (done_cnt > 0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", got, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_accel_start"}, accel_start, 0);
    check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_s_tready"}, s_axis_tready, 0);
    check({tag, "_tlast_err"}, tlast_err, 0);
    check({tag, "_timeout"}, timeout, 0);
    for (int k = 0; k < RES; k++) begin
      rd_addr = RD_AW'(k);
      #1;
      check({tag, "_rd_data"}, rd_data, 0);
    end
  endtask

  // One full transaction with the given result pattern.
  task automatic run_txn(input int n_res, input int tlast_at, input int base,
                         input bit rnd_ready, input bit wait_recv,
                         input bit exp_to, input bit busy_writes);
    bit exp_err;
    acc_cnt = 0;
    done_cnt = 0;
    beat_cnt = 0;
    to_cyc = -1;
    rand_ready = rnd_ready;
    exp_q.delete();
    for (int i = 0; i < OPS; i++) exp_q.push_back(op_model[i]);
    pulse_start();
    fork
      send_results(n_res, tlast_at, base, wait_recv);
      if (busy_writes) busy_write_burst();
    join
    wait_done();
    rand_ready = 1'b0;
    // tlast is correct only when it marks exactly the N*N-th beat.
    exp_err = (tlast_at >= 0 && tlast_at < n_res && tlast_at != RES - 1) ||
              (n_res == RES && tlast_at != RES - 1);
    check("accel_start_pulses", acc_cnt, 1);
    check("done_pulses", done_cnt, 1);
    check("operand_beats", beat_cnt, OPS);
    check("operands_left", exp_q.size(), 0);
    check("busy_after", busy, 0);
    check("tlast_err", tlast_err, exp_err);
    check("timeout", timeout, exp_to);
    // timeout is registered on the 20th edge after the accepting edge, so it
    // is first seen 21 falling edges after the one preceding acceptance.
    if (exp_to) check("timeout_delay", to_cyc - acc_cyc, TIMEOUT + 1);
    for (int k = 0; k < RES; k++) begin
      rd_addr = RD_AW'(k);
      #1;
      check("rd_data", rd_data, res_model[k]);
    end
  endtask

  task automatic reset_mid_send();
    bit ok = 1'b0;
    load_ops(1'b0);
    done_cnt = 0;
    beat_cnt = 0;
    rand_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < OPS; i++) exp_q.push_back(op_model[i]);
    pulse_start();
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (beat_cnt >= 10) begin
        ok = 1'b1;
        break;
      end
    end
    check("ten_beats_before_reset", ok, 1);
    #1 rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    for (int i = 0; i < OPS; i++) op_model[i] = '0;
    for (int k = 0; k < RES; k++) res_model[k] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("no_done_after_abort", done_cnt, 0);
    load_ops(1'b0);
    run_txn(RES, RES - 1, -1, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mon_prev_stall = 1'b0;
      mon_prev_to = 1'b0;
    end else begin
      if (mon_prev_stall) begin
        check("hold_tvalid", m_axis_tvalid, 1);
        check("hold_tdata", m_axis_tdata, mon_prev_data);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beat_cnt++;
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("m_tdata", m_axis_tdata, exp_q.pop_front());
      end
      mon_prev_stall = m_axis_tvalid && !m_axis_tready;
      mon_prev_data = m_axis_tdata;
      if (accel_start) acc_cnt++;
      if (done) begin
        done_cnt++;
        check("done_not_busy", busy, 0);
      end
      if (timeout && !mon_prev_to) to_cyc = cyc;
      mon_prev_to = timeout;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    ld_we = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    rd_addr = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tlast = 1'b0;
    for (int k = 0; k < RES; k++) res_model[k] = '0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Operands 1..32, results 100..115 returned in RECV with tlast on the last.
    load_ops(1'b1);
    run_txn(RES, RES - 1, 100, 1'b0, 1'b1, 1'b0, 1'b0);
    // Same operands under random backpressure, results arriving during SEND.
    run_txn(RES, RES - 1, -1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Early tlast on beat 5, then no tlast at all.
    load_ops(1'b0);
    run_txn(RES, 4, -1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn(RES, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Three results then a stall: watchdog ends the transaction.
    run_txn(3, -1, -1, 1'b0, 1'b1, 1'b1, 1'b0);
    // Host writes during busy are ignored.
    load_ops(1'b0);
    run_txn(RES, RES - 1, -1, 1'b1, 1'b0, 1'b0, 1'b1);
    // Reset in the middle of the operand stream, then a fresh transaction.
    reset_mid_send();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matrix_stream_host.md
MATRIX_STREAM_HOST -- requirements
Module: matrix_stream_host

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 16, operand width.
- ACC_W, default 32, result width.
- N, default 4, matrix dimension.
- TIMEOUT, default 1024, maximum idle cycles allowed between result beats.

REQ-002 Ports SHALL be as follows. There is one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a transaction.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- tlast_err  out  1  sticky tlast mismatch flag.
- timeout  out  1  sticky watchdog flag.
- accel_start  out  1  one-cycle start pulse to the accelerator.
- ld_we  in  1  operand write enable.
- ld_addr  in  clog2(2*N*N)  operand index; A row-major occupies 0..N*N-1, B row-major occupies N*N..2*N*N-1.
- ld_data  in  DATA_W  operand value.
- rd_addr  in  clog2(N*N)  result index.
- rd_data  out  ACC_W  result value, combinational read.
- m_axis_tvalid, m_axis_tdata[DATA_W], m_axis_tready: AXI-Stream master carrying operands to the accelerator.
- s_axis_tvalid, s_axis_tdata[ACC_W], s_axis_tlast, s_axis_tready: AXI-Stream slave accepting results from the accelerator.

Function
REQ-003 The FSM SHALL have the states IDLE, KICK, SEND, RECV and FIN.
REQ-004 In IDLE, start=1 SHALL move the FSM to KICK; in IDLE, busy SHALL be 0.
REQ-005 KICK SHALL last exactly one cycle with accel_start=1, then move to SEND.
REQ-006 busy SHALL be 1 in KICK, SEND and RECV, and 0 in IDLE and FIN.
REQ-007 In SEND, m_axis_tvalid SHALL be 1 and m_axis_tdata SHALL equal op_buf[send_idx], where send_idx starts at 0.
REQ-008 A beat SHALL transfer only when tvalid and tready are both 1; send_idx SHALL increment on each transfer.
REQ-009 Once asserted, tvalid and tdata SHALL remain stable until the beat transfers, including for arbitrarily long tready=0.
REQ-010 After the transfer with send_idx=2*N*N-1, the FSM SHALL move to RECV and m_axis_tvalid SHALL be 0 in the next cycle.
REQ-011 s_axis_tready SHALL be 1 in both SEND and RECV, so that early results are accepted.
REQ-012 Each accepted result beat SHALL write res_buf[recv_idx] and increment recv_idx, which starts at 0.
REQ-013 tlast_err SHALL set on either of these conditions:
- s_axis_tlast=1 on an accepted beat with recv_idx<N*N-1;
- s_axis_tlast=0 on the beat with recv_idx=N*N-1.
REQ-014 Collection SHALL continue to N*N beats regardless of tlast.
REQ-015 When the beat with recv_idx=N*N-1 is accepted:
- if it is accepted in RECV, the FSM SHALL go to FIN;
- if it is accepted in SEND, the FSM SHALL go to FIN after the final operand transfer.
REQ-016 In RECV, a watchdog SHALL count cycles since the last accepted beat and clear on each accepted beat; reaching TIMEOUT SHALL set timeout and move the FSM to FIN.
REQ-017 FIN SHALL last one cycle with done=1, then move to IDLE.
REQ-018 In any non-IDLE state, start SHALL be ignored.
REQ-019 ld_we SHALL write op_buf[ld_addr] only in IDLE; it SHALL be ignored otherwise and for ld_addr>=2*N*N.
REQ-020 rd_data SHALL reflect res_buf[rd_addr] at all times.
REQ-021 tlast_err and timeout SHALL clear on the KICK cycle and otherwise hold until the next start.
REQ-022 Latency SHALL be: start in cycle t gives accel_start at t+1 and the first m_axis_tvalid at t+2. With tready always 1 and results arriving promptly, the last operand SHALL transfer at t+2+2*N*N-1.

Reset
REQ-023 While rst=1, independent of clk, the block SHALL be in the following state:
- FSM in IDLE;
- busy, done, accel_start, m_axis_tvalid and s_axis_tready at 0;
- tlast_err and timeout at 0;
- send_idx, recv_idx and the watchdog at 0;
- op_buf and res_buf cleared to 0.
REQ-024 Reset asserted mid-transaction SHALL abort the transaction with no done pulse. The first start after release SHALL begin a fresh transaction from index 0.

Verification
REQ-025 Basic stream: load op_buf[i]=i+1 for i=0..31 (N=4), pulse start, hold m_axis_tready=1. Required: exactly one accel_start pulse, and 32 beats with tdata 1..32 in order.
REQ-026 Backpressure: the same stimulus with m_axis_tready toggling pseudo-randomly. Required: tdata and tvalid stable while tready=0, the same 1..32 sequence, and no beat dropped or duplicated.
REQ-027 Result collection: return 16 beats with values 100..115 and tlast on the 16th. Required: a single done pulse, rd_data(k)=100+k, tlast_err=0, timeout=0.
REQ-028 Early and missing tlast: first run with tlast on beat 5, then run with no tlast at all. Required: tlast_err=1 in both runs, all 16 results stored, and done pulsed.
REQ-029 Timeout: with TIMEOUT=20, return 3 results and then stall. Required: timeout=1 exactly 20 cycles after the 3rd beat, done pulses, and rd_data(0..2) is correct.
REQ-030 Reset mid-SEND: assert rst after 10 operand beats. Required: all outputs at 0 immediately; a new start then streams from op index 0, and ld_we during busy does not alter op_buf.
